// File: rtl/cache_controller_if.sv
// CPU / cache / main-memory signal bundle for the read-only cache controller.
// The slave modport is the controller; master is whatever surrounds it.
interface cache_controller_if #(
   parameter int WORD = 32,
   parameter int ADRW = 15
);
   logic            reqValid;
   logic [ADRW-1:0] reqAddr;
   logic            reqReady;
   logic            respValid;
   logic [WORD-1:0] respData;
   logic [ADRW-1:0] address;
   logic            cRead;
   logic            hit;
   logic [WORD-1:0] dataOutCache;
   logic            cWrite;
   logic [ADRW-1:0] adr0, adr1, adr2, adr3;
   logic [WORD-1:0] block0, block1, block2, block3;
   logic            memRead;
   logic [ADRW-1:0] memAddr;
   logic            memReady;
   logic [WORD-1:0] memData;
   logic [14:0]     misses;

   modport master (
      output reqValid, reqAddr, hit, dataOutCache, memReady, memData,
      input  reqReady, respValid, respData, address, cRead, cWrite,
             adr0, adr1, adr2, adr3, block0, block1, block2, block3,
             memRead, memAddr, misses
   );

   modport slave (
      input  reqValid, reqAddr, hit, dataOutCache, memReady, memData,
      output reqReady, respValid, respData, address, cRead, cWrite,
             adr0, adr1, adr2, adr3, block0, block1, block2, block3,
             memRead, memAddr, misses
   );
endinterface

// File: rtl/cache_controller.sv
// Read-only cache controller: lookup, 4-word block fetch from main memory on a
// miss, single-cycle block fill, then a one-cycle response pulse to the CPU.
//
// state     | meaning
// S_IDLE    | ready for a CPU request
// S_LOOKUP  | cache read of the latched address
// S_FETCH   | reading the 4 block words from main memory
// S_FILL    | one-cycle block write into the cache
// S_RESPOND | respValid pulse
module cache_controller #(
   parameter int WORD = 32,
   parameter int ADRW = 15
) (
   input  logic         clk,
   input  logic         rst,
   cache_controller_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_FETCH, S_FILL, S_RESPOND
   } state_t;

   localparam logic [14:0] MISS_MAX = 15'h7FFF;

   state_t          r_state, w_next;
   logic [ADRW-1:0] r_addr;
   logic [1:0]      r_k;
   logic [14:0]     r_misses;
   logic [WORD-1:0] r_buf   [4];
   logic [WORD-1:0] r_resp;
   logic [ADRW-1:0] r_adr   [4];
   logic [WORD-1:0] r_block [4];
   logic            w_req_ready, w_cread, w_mem_read, w_cwrite, w_resp_valid;
   logic            w_last_word;

   assign w_last_word = (r_state == S_FETCH) && bus.memReady && (r_k == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bus.reqValid) w_next = S_LOOKUP;
         S_LOOKUP:  w_next = bus.hit ? S_RESPOND : S_FETCH;
         S_FETCH:   if (w_last_word) w_next = S_FILL;
         S_FILL:    w_next = S_RESPOND;
         S_RESPOND: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready  = 1'b0;
      w_cread      = 1'b0;
      w_mem_read   = 1'b0;
      w_cwrite     = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         S_IDLE:    w_req_ready  = 1'b1;
         S_LOOKUP:  w_cread      = 1'b1;
         S_FETCH:   w_mem_read   = 1'b1;
         S_FILL:    w_cwrite     = 1'b1;
         S_RESPOND: w_resp_valid = 1'b1;
         default:   ;
      endcase
   end

   // Fill address/data registers are loaded on the edge that enters S_FILL so
   // they are already valid during the cWrite cycle and then hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr   <= '0;
         r_k      <= '0;
         r_misses <= '0;
         r_resp   <= '0;
         for (int i = 0; i < 4; i++) begin
            r_buf[i]   <= '0;
            r_adr[i]   <= '0;
            r_block[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: if (bus.reqValid) r_addr <= bus.reqAddr;
            S_LOOKUP: begin
               if (bus.hit) begin
                  r_resp <= bus.dataOutCache;
               end else begin
                  r_k <= '0;
                  if (r_misses != MISS_MAX) r_misses <= r_misses + 15'd1;
               end
            end
            S_FETCH: begin
               if (bus.memReady) begin
                  r_buf[r_k] <= bus.memData;
                  r_k        <= r_k + 2'd1;
               end
               if (w_last_word) begin
                  for (int i = 0; i < 4; i++) begin
                     r_adr[i] <= {r_addr[ADRW-1:2], 2'(i)};
                  end
                  for (int i = 0; i < 3; i++) r_block[i] <= r_buf[i];
                  r_block[3] <= bus.memData;
               end
            end
            S_FILL: r_resp <= r_buf[r_addr[1:0]];
            default: ;
         endcase
      end
   end

   assign bus.reqReady  = w_req_ready;
   assign bus.respValid = w_resp_valid;
   assign bus.respData  = r_resp;
   assign bus.address   = r_addr;
   assign bus.cRead     = w_cread;
   assign bus.cWrite    = w_cwrite;
   assign bus.memRead   = w_mem_read;
   assign bus.memAddr   = {r_addr[ADRW-1:2], r_k};
   assign bus.misses    = r_misses;
   assign bus.adr0      = r_adr[0];
   assign bus.adr1      = r_adr[1];
   assign bus.adr2      = r_adr[2];
   assign bus.adr3      = r_adr[3];
   assign bus.block0    = r_block[0];
   assign bus.block1    = r_block[1];
   assign bus.block2    = r_block[2];
   assign bus.block3    = r_block[3];
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed vector table, reset and
// saturation sequences, then randomized transactions against a reference model.
module tb_cache_controller;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cache_controller_if #(.WORD(32), .ADRW(15)) bus ();
   cache_controller #(.WORD(32), .ADRW(15)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int ref_misses = 0;

   typedef struct {
      logic [14:0] addr;
      logic        hit;
      logic [31:0] cdata;
      int          gap;
      bit          hold;
      logic [31:0] exp_resp;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Main-memory contents: block 0x2004..0x2007 holds 0xA0..0xA3, else a hash.
   function automatic logic [31:0] mdat(input logic [14:0] a);
      if (a[14:2] == 13'h0801) return 32'hA0 + 32'(a[1:0]);
      return {a[7:0], ~a, a[8:0]};
   endfunction

   task automatic run_txn(input logic [14:0] a, input logic h, input logic [31:0] cd,
                          input int gap, input bit hold,
                          input logic [31:0] exp_resp, input int exp_lat);
      int words, g, n_cread, n_memrd, n_cw, lat;
      bit done;
      logic [14:0] base;
      base = {a[14:2], 2'b00};
      @(negedge clk);
      check("req_ready_idle", 64'(bus.reqReady), 64'd1);
      bus.reqValid = 1'b1;
      bus.reqAddr = a;
      bus.hit = h;
      bus.dataOutCache = cd;
      bus.memReady = 1'b0;
      words = 0; g = 0; n_cread = 0; n_memrd = 0; n_cw = 0; lat = 0; done = 1'b0;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         if (!hold) bus.reqValid = 1'b0;
         if (cyc == 1) begin
            check("lookup_addr", 64'(bus.address), 64'(a));
            check("req_ready_busy", 64'(bus.reqReady), 64'd0);
         end
         if (bus.cRead) n_cread++;
         if (bus.cWrite) begin
            n_cw++;
            check("fill_adr0", 64'(bus.adr0), 64'(base));
            check("fill_adr1", 64'(bus.adr1), 64'(base + 15'd1));
            check("fill_adr2", 64'(bus.adr2), 64'(base + 15'd2));
            check("fill_adr3", 64'(bus.adr3), 64'(base + 15'd3));
            check("fill_blk0", 64'(bus.block0), 64'(mdat(base)));
            check("fill_blk1", 64'(bus.block1), 64'(mdat(base + 15'd1)));
            check("fill_blk2", 64'(bus.block2), 64'(mdat(base + 15'd2)));
            check("fill_blk3", 64'(bus.block3), 64'(mdat(base + 15'd3)));
         end
         if (bus.memRead) begin
            n_memrd++;
            check("mem_addr", 64'(bus.memAddr), 64'({a[14:2], 2'(words)}));
            if (g == gap) begin
               bus.memReady = 1'b1;
               bus.memData = mdat(bus.memAddr);
               words++;
               g = 0;
            end else begin
               bus.memReady = 1'b0;
               bus.memData = $urandom;
               g++;
            end
         end else begin
            bus.memReady = 1'($urandom_range(0, 1));
            bus.memData = $urandom;
         end
         if (bus.respValid) begin
            done = 1'b1;
            lat = cyc;
            bus.reqValid = 1'b0;
         end
      end
      bus.memReady = 1'b0;
      if (!done) begin
         check("resp_timeout", 64'd0, 64'd1);
      end else begin
         if (!h && ref_misses < 32767) ref_misses++;
         check("latency", 64'(lat), 64'(exp_lat));
         check("resp_data", 64'(bus.respData), 64'(exp_resp));
         check("cread_cycles", 64'(n_cread), 64'd1);
         check("cwrite_pulses", 64'(n_cw), h ? 64'd0 : 64'd1);
         check("memread_cycles", 64'(n_memrd), h ? 64'd0 : 64'(4 * (gap + 1)));
         check("misses", 64'(bus.misses), 64'(ref_misses));
         if (!h) check("adr_hold", 64'(bus.adr0), 64'(base));
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.reqValid = 1'b0;
         bus.memReady = 1'($urandom_range(0, 1));
         bus.memData = $urandom;
         check("idle_ready", 64'(bus.reqReady), 64'd1);
         check("idle_strobes", 64'({bus.memRead, bus.cWrite, bus.cRead, bus.respValid}), 64'd0);
      end
      bus.memReady = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_strobes"}, 64'({bus.memRead, bus.cWrite, bus.cRead, bus.respValid}), 64'd0);
      check({tag, "_ready"}, 64'(bus.reqReady), 64'd1);
      check({tag, "_resp"}, 64'(bus.respData), 64'd0);
      check({tag, "_misses"}, 64'(bus.misses), 64'd0);
      check({tag, "_addrs"}, 64'({bus.address, bus.memAddr, bus.adr0, bus.adr1}), 64'd0);
      check({tag, "_adr23"}, 64'({bus.adr2, bus.adr3}), 64'd0);
      check({tag, "_blk01"}, {bus.block0, bus.block1}, 64'd0);
      check({tag, "_blk23"}, {bus.block2, bus.block3}, 64'd0);
   endtask

   vec_t vecs[6];

   initial begin
      int words;
      logic [14:0] ra;
      logic rh;
      logic [31:0] rcd;
      int rgap;
      bit rhold;

      vecs[0] = '{15'h1234, 1'b1, 32'hCAFEBABE, 0, 1'b0, 32'hCAFEBABE, 2};
      vecs[1] = '{15'h2006, 1'b0, 32'h0,        0, 1'b0, 32'hA2,       7};
      vecs[2] = '{15'h2005, 1'b0, 32'h0,        3, 1'b0, 32'hA1,       19};
      vecs[3] = '{15'h2007, 1'b0, 32'h0,        1, 1'b1, 32'hA3,       11};
      vecs[4] = '{15'h2004, 1'b1, 32'h12345678, 0, 1'b1, 32'h12345678, 2};
      vecs[5] = '{15'h7FFF, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 32'hFFFFFFFF, 2};

      bus.reqValid = 1'b0;
      bus.reqAddr = '0;
      bus.hit = 1'b0;
      bus.dataOutCache = '0;
      bus.memReady = 1'b0;
      bus.memData = '0;

      #3;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(3);

      foreach (vecs[i]) begin
         run_txn(vecs[i].addr, vecs[i].hit, vecs[i].cdata, vecs[i].gap, vecs[i].hold,
                 vecs[i].exp_resp, vecs[i].exp_lat);
         idle_cycles(2);
      end

      // Reset in the middle of a fetch, after two words have been captured.
      @(negedge clk);
      bus.reqValid = 1'b1;
      bus.reqAddr = 15'h3009;
      bus.hit = 1'b0;
      words = 0;
      for (int c = 0; c < 20 && words < 2; c++) begin
         @(negedge clk);
         bus.reqValid = 1'b0;
         if (bus.memRead) begin
            bus.memReady = 1'b1;
            bus.memData = mdat(bus.memAddr);
            words++;
         end else begin
            bus.memReady = 1'b0;
         end
      end
      check("rst_pre_words", 64'(words), 64'd2);
      @(posedge clk);
      #1;
      bus.memReady = 1'b0;
      check("rst_pre_fetch", 64'({bus.memRead, bus.memAddr}), 64'({1'b1, 15'h300A}));
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_fetch_rst");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_hold_strobes", 64'({bus.memRead, bus.cWrite, bus.respValid}), 64'd0);
      end
      rst = 1'b1;
      ref_misses = 0;
      run_txn(15'h3009, 1'b0, 32'h0, 0, 1'b0, mdat(15'h3009), 7);
      idle_cycles(2);

      // Preload the counter near its ceiling rather than running 32k misses.
      @(negedge clk);
      dut.r_misses = 15'h7FFE;
      ref_misses = 32766;
      run_txn(15'h0100, 1'b0, 32'h0, 0, 1'b0, mdat(15'h0100), 7);
      check("sat_reach", 64'(bus.misses), 64'h7FFF);
      run_txn(15'h0203, 1'b0, 32'h0, 0, 1'b0, mdat(15'h0203), 7);
      check("sat_hold", 64'(bus.misses), 64'h7FFF);
      run_txn(15'h0203, 1'b1, 32'h5A5A5A5A, 0, 1'b0, 32'h5A5A5A5A, 2);

      for (int t = 0; t < 40; t++) begin
         ra = 15'($urandom);
         rh = 1'($urandom_range(0, 1));
         rcd = $urandom;
         rgap = $urandom_range(0, 2);
         rhold = 1'($urandom_range(0, 1));
         run_txn(ra, rh, rcd, rgap, rhold, rh ? rcd : mdat(ra), rh ? 2 : 3 + 4 * (rgap + 1));
         idle_cycles($urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning data word width.
REQ-002 SHALL have parameter ADRW, default 15, meaning address width (3-bit tag, 12-bit cache index).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 reqValid  input  1  CPU read request.
REQ-006 reqAddr  input  ADRW  CPU word address.
REQ-007 reqReady  output  1  controller can accept a request.
REQ-008 respValid  output  1  one-cycle pulse: respData is valid.
REQ-009 respData  output  WORD  read data returned to CPU.
REQ-010 address  output  ADRW  lookup address driven to the cache.
REQ-011 cRead  output  1  cache read enable.
REQ-012 hit  input  1  cache hit flag for the current address.
REQ-013 dataOutCache  input  WORD  cache read data.
REQ-014 cWrite  output  1  cache block-fill strobe.
REQ-015 adr0..adr3  output  ADRW each  fill addresses, words 0..3 of the block.
REQ-016 block0..block3  output  WORD each  fill data, words 0..3.
REQ-017 memRead  output  1  main-memory word read request.
REQ-018 memAddr  output  ADRW  main-memory word address.
REQ-019 memReady  input  1  memData valid this cycle.
REQ-020 memData  input  WORD  main-memory read data.
REQ-021 misses  output  15  saturating miss counter.

Function
REQ-022 FSM states SHALL be IDLE, LOOKUP, FETCH, FILL, RESPOND.
REQ-023 IDLE: reqReady=1; on reqValid latch reqAddr into A, go LOOKUP; reqReady=0 in all other states.
REQ-024 LOOKUP: address=A, cRead=1; hit=1 -> capture dataOutCache into respData, go RESPOND; hit=0 -> clear word counter k, increment misses, go FETCH.
REQ-025 FETCH: memRead=1, memAddr={A[ADRW-1:2],k}; on memReady store memData in buffer[k], increment k; the fourth memReady (k=3) goes FILL.
REQ-026 FILL: cWrite=1 for exactly one cycle; adrN={A[ADRW-1:2],N}; blockN=buffer[N]; respData<=buffer[A[1:0]]; go RESPOND.
REQ-027 RESPOND: respValid=1 for exactly one cycle, respData held; go IDLE.
REQ-028 Hit latency SHALL be 2 cycles from the accepting edge to the respValid cycle.
REQ-029 Miss latency SHALL be 3 cycles plus the FETCH cycles.
REQ-030 FETCH SHALL wait indefinitely for memReady, with memRead held high and memAddr stable.
REQ-031 memReady outside FETCH SHALL be ignored.
REQ-032 reqValid outside IDLE SHALL be ignored; no request queuing.
REQ-033 misses SHALL saturate at 32767 with no wrap.
REQ-034 cWrite, memRead, cRead and respValid SHALL never be high outside their stated states.
REQ-035 adr0..adr3 and block0..block3 SHALL hold their last values outside FILL.

Reset
REQ-036 rst low SHALL asynchronously force IDLE, k=0, misses=0, buffer and respData to zero, all adr/block outputs to zero, and all strobes low.
REQ-037 rst low mid-FETCH or mid-FILL SHALL abort the operation with no cWrite pulse; after rst rises, the first edge is in IDLE.

Verification
REQ-038 Hit: reqAddr=0x1234 with hit=1 and dataOutCache=0xCAFEBABE -> respValid exactly 2 cycles later, respData=0xCAFEBABE, misses unchanged.
REQ-039 Miss: reqAddr=0x2006 with hit=0 and memory returning 0xA0..0xA3 with memReady every cycle -> memAddr 0x2004..0x2007; one cWrite with adr0..3=0x2004..0x2007 and block0..3=0xA0..0xA3; respData=0xA2; misses=1.
REQ-040 Stalled memory: memReady gaps of 3 idle cycles between words -> memAddr stable during each gap, exactly 4 words captured, one cWrite.
REQ-041 Saturation: misses preloaded to 32767 via 32767 misses, one more miss -> misses stays 32767.
REQ-042 Reset mid-FETCH after 2 words -> all outputs zero immediately, no cWrite; next request is handled normally.
REQ-043 Spurious inputs: memReady pulses in IDLE and reqValid held during FETCH -> no state change and no second request accepted.
